wb_sequencer: RTL and testbench
===============================

# wb_sequencer

Writeback sequencer for the multicycle MIPS datapath. It arbitrates register-file writeback requests from up to `N_REQ` producers (ALU, load unit, mult/div, misc) using round-robin. For each granted request it drives the 4-bit `MemtoReg` select of the 9-input writeback mux and the destination register address, then pulses `RegWrite` once the mux select has been stable for a full cycle. It sits between the control FSM/functional units and the writeback mux plus register bank.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters. Legal range 2..8.

Ports:
- `clk`, input, 1: rising-edge clock.
- `reset_n`, input, 1: synchronous, active-low reset.
- `req`, input, `N_REQ`: per-requester writeback request (level). Must be held until `ack`.
- `req_sel`, input, `4*N_REQ`: per-requester mux select. Slice i is bits `[4i+3:4i]`. Legal codes are 4'b0000..4'b1000.
- `req_dst`, input, `5*N_REQ`: per-requester destination register. Slice i is bits `[5i+4:5i]`.
- `stall`, input, 1: datapath stall. Blocks new grants and holds SETUP.
- `ack`, output, `N_REQ`: one-hot, one-cycle completion pulse to the granted requester.
- `MemtoReg`, output, 4: registered writeback-mux select.
- `WriteRegAddr`, output, 5: registered destination register.
- `RegWrite`, output, 1: one-cycle register-file write enable.
- `busy`, output, 1: high when the state is not IDLE.
- `sel_err`, output, 1: one-cycle pulse when an illegal select is retired.

## Operation

- FSM states: IDLE, SETUP, WRITE.
- **Round-robin arbitration:**
  - The priority pointer `rr_ptr` is reset to 0.
  - The winner is the first requester with `req` set, searching from `rr_ptr` upward and wrapping at `N_REQ`.
  - After a grant to requester i, `rr_ptr` becomes (i+1) mod `N_REQ`.
- **IDLE:**
  - If `stall`=0 and any `req` is set, latch the winner index, `MemtoReg`←sel[i] and `WriteRegAddr`←dst[i], then go to SETUP.
  - Otherwise stay in IDLE.
- **SETUP:**
  - Outputs are held.
  - If `stall`=1, stay in SETUP. Otherwise go to WRITE.
- **WRITE:**
  - `ack[i]`=1.
  - `RegWrite`=1 only if the latched select is legal (≤4'b1000) and `WriteRegAddr`≠0. A write to `$0` is acked but suppressed.
  - An illegal select gives `RegWrite`=0 and `sel_err`=1, and the request is still acked (dropped).
  - Re-arbitration happens in the same cycle with the granted requester's bit masked:
    - if another request is pending and `stall`=0, latch it and go directly to SETUP;
    - otherwise go to IDLE.
- `MemtoReg` and `WriteRegAddr` keep their last granted values while IDLE; they are never cleared outside reset.
- After seeing `ack`, a requester that keeps `req` high on the following cycle is treated as issuing a new request.
- A change of `req_sel`/`req_dst` while a request is pending but not yet granted is allowed. Values are sampled only at the grant edge.

## Timing

- **Reset values:**
  - `MemtoReg`=4'b0000, `WriteRegAddr`=0.
  - `RegWrite`, `ack`, `busy` and `sel_err` all 0.
  - State is IDLE and `rr_ptr`=0.
- **Reset mid-operation:** the state returns to IDLE at once. No `ack` and no `RegWrite` are issued for the aborted request.
- **Latency:** `req` sampled high at edge t → SETUP during cycle t+1 → `RegWrite`/`ack` during cycle t+2.
- **Throughput:** with back-to-back requesters, one write every 2 cycles (WRITE→SETUP→WRITE).
- `MemtoReg` is stable for at least one full cycle before and during `RegWrite`.
- **Simultaneous requests:** exactly one grant per arbitration, always by round-robin order. Fixed priority is never used.
- `stall` is sampled every cycle:
  - it holds SETUP indefinitely;
  - in WRITE it does not cancel the current write, but it blocks the chained grant (the FSM goes to IDLE).

## Configuration

- `WB_FAST_PATH_EN`:
  - When defined, SETUP is removed. IDLE/WRITE grants go straight to WRITE, giving 1-cycle latency and 1 write per cycle.
  - In that mode `MemtoReg` is still registered at grant, so it changes on the same edge that `RegWrite` rises.
  - `stall` then gates grants only.
- When undefined, the 3-state behaviour above applies.

## Test plan

- Reset with `req`=4'b1111 held → all outputs 0, and after release the first ack goes to requester 0.
- Requester 2 alone, sel=4'b0011, dst=5'd8 → `MemtoReg`=3 from t+1, `RegWrite`=1 with `WriteRegAddr`=8 and `ack`=4'b0100 at t+2.
- All 4 requesting continuously → `ack` order 0,1,2,3,0 with `RegWrite` every 2nd cycle.
- Requester 1, dst=0 → `ack[1]`=1 and `RegWrite`=0. Requester 3, sel=4'b1011 → `ack[3]`=1, `RegWrite`=0, `sel_err`=1 for one cycle.
- `stall`=1 for 3 cycles while in SETUP → FSM stays in SETUP with outputs held, and `RegWrite` occurs the cycle after `stall` falls.
- `reset_n`=0 during SETUP → no ack/write issued, `busy`=0 the next cycle, `rr_ptr` back to 0.

Source files
------------

// File: rtl/wb_sequencer.sv
// Round-robin writeback sequencer for the multicycle MIPS register-file write port.
// Optional WB_FAST_PATH_EN removes SETUP: grants go straight to WRITE (1-cycle latency).
module wb_sequencer #(
  parameter int N_REQ = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] req_sel,
  input  logic [5*N_REQ-1:0] req_dst,
  input  logic               stall,
  output logic [N_REQ-1:0]   ack,
  output logic [3:0]         MemtoReg,
  output logic [4:0]         WriteRegAddr,
  output logic               RegWrite,
  output logic               busy,
  output logic               sel_err
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned SW = PW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, WRITE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    grant_q, grant_d;
  logic [3:0]       sel_q, sel_d;
  logic [4:0]       dst_q, dst_d;

  logic [N_REQ-1:0] grant_oh;
  logic [N_REQ-1:0] cand;
  logic             win_vld;
  logic [PW-1:0]    win_idx;
  logic [SW-1:0]    sum;
  logic             take;
  logic             sel_ok;

  logic [3:0]       sel_a [N_REQ];
  logic [4:0]       dst_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign sel_a[g] = req_sel[4*g+3:4*g];
    assign dst_a[g] = req_dst[5*g+4:5*g];
  end

  // The requester being retired in WRITE is masked so a held req is not re-granted at once.
  always_comb begin
    grant_oh = '0;
    grant_oh[grant_q] = 1'b1;
    cand     = (state_q == WRITE) ? (req & ~grant_oh) : req;
    win_vld  = 1'b0;
    win_idx  = '0;
    sum      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + SW'(k);
      if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
      if (!win_vld && cand[sum[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = sum[PW-1:0];
      end
    end
    take = win_vld && !stall && (state_q == IDLE || state_q == WRITE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      sel_q    <= '0;
      dst_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      dst_q    <= dst_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    sel_d    = sel_q;
    dst_d    = dst_q;
    case (state_q)
      IDLE, WRITE: begin
        if (take) begin
          grant_d  = win_idx;
          sel_d    = sel_a[win_idx];
          dst_d    = dst_a[win_idx];
          rr_ptr_d = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
`ifdef WB_FAST_PATH_EN
          state_d  = WRITE;
`else
          state_d  = SETUP;
`endif
        end else begin
          state_d  = IDLE;
        end
      end
      SETUP:   if (!stall) state_d = WRITE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_ok   = (sel_q <= 4'd8);
    ack      = '0;
    RegWrite = 1'b0;
    sel_err  = 1'b0;
    busy     = (state_q != IDLE);
    if (state_q == WRITE) begin
      ack      = grant_oh;
      RegWrite = sel_ok && (dst_q != 5'd0);
      sel_err  = !sel_ok;
    end
  end

  assign MemtoReg     = sel_q;
  assign WriteRegAddr = dst_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: directed vector table, a hand-written sequence, then random
// traffic checked against a request-level round-robin model.
module tb_wb_sequencer;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           stall;
  logic [N-1:0]   req;
  logic [4*N-1:0] req_sel;
  logic [5*N-1:0] req_dst;
  logic [N-1:0]   ack;
  logic [3:0]     MemtoReg;
  logic [4:0]     WriteRegAddr;
  logic           RegWrite;
  logic           busy;
  logic           sel_err;

  int total = 0;
  int bad   = 0;

  wb_sequencer #(.N_REQ(N)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_sel(req_sel), .req_dst(req_dst),
    .stall(stall), .ack(ack), .MemtoReg(MemtoReg), .WriteRegAddr(WriteRegAddr),
    .RegWrite(RegWrite), .busy(busy), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic       stall;
    logic [3:0] req;
    logic       busy;
    logic [3:0] ack;
    logic       rw;
    logic [3:0] mtr;
    logic [4:0] wra;
    logic       err;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic [3:0] q, logic b, logic [3:0] a,
                              logic w, logic [3:0] m, logic [4:0] d, logic e);
    vec_t v;
    v.rst_n = r; v.stall = s; v.req = q; v.busy = b; v.ack = a;
    v.rw = w; v.mtr = m; v.wra = d; v.err = e;
    return v;
  endfunction

  // Reference model: tracks the one outstanding grant and its phase
  // (0 = nothing granted, 1 = waiting out the setup cycle, 2 = writing).
  int       m_ph, m_ptr, m_g;
  logic [3:0] m_sel;
  logic [4:0] m_dst;

  function automatic int pick(logic [N-1:0] m, int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [N-1:0] m;
    int w;
    if (!reset_n) begin
      m_ph = 0; m_ptr = 0; m_g = 0; m_sel = '0; m_dst = '0;
    end else if (m_ph == 1) begin
      if (!stall) m_ph = 2;
    end else begin
      m = req;
      if (m_ph == 2) m[m_g] = 1'b0;
      w = stall ? -1 : pick(m, m_ptr);
      if (w >= 0) begin
        m_g = w;
        m_sel = req_sel[4*w +: 4];
        m_dst = req_dst[5*w +: 5];
        m_ptr = (w + 1) % N;
`ifdef WB_FAST_PATH_EN
        m_ph = 2;
`else
        m_ph = 1;
`endif
      end else begin
        m_ph = 0;
      end
    end
  endtask

  vec_t vt[$];
  logic [N-1:0] e_ack;

  initial begin
    reset_n = 1'b0; stall = 1'b0; req = '0;
    req_sel = 16'hB321;
    req_dst = {5'd9, 5'd8, 5'd0, 5'd5};

    //         rst stl req    busy ack   rw  mtr    wra    err
    vt.push_back(mk(0, 0, 4'hF, 0, 4'h0, 0, 4'h0, 5'd0, 0));
    vt.push_back(mk(0, 0, 4'hF, 0, 4'h0, 0, 4'h0, 5'd0, 0));
    vt.push_back(mk(1, 0, 4'hF, 1, 4'h0, 0, 4'h1, 5'd5, 0));
    vt.push_back(mk(1, 0, 4'hF, 1, 4'h1, 1, 4'h1, 5'd5, 0));
    vt.push_back(mk(1, 0, 4'hF, 1, 4'h0, 0, 4'h2, 5'd0, 0));
    vt.push_back(mk(1, 0, 4'hF, 1, 4'h2, 0, 4'h2, 5'd0, 0));
    vt.push_back(mk(1, 0, 4'hF, 1, 4'h0, 0, 4'h3, 5'd8, 0));
    vt.push_back(mk(1, 0, 4'hF, 1, 4'h4, 1, 4'h3, 5'd8, 0));
    vt.push_back(mk(1, 0, 4'hF, 1, 4'h0, 0, 4'hB, 5'd9, 0));
    vt.push_back(mk(1, 0, 4'hF, 1, 4'h8, 0, 4'hB, 5'd9, 1));
    vt.push_back(mk(1, 0, 4'hF, 1, 4'h0, 0, 4'h1, 5'd5, 0));
    vt.push_back(mk(1, 1, 4'hF, 1, 4'h0, 0, 4'h1, 5'd5, 0));
    vt.push_back(mk(1, 1, 4'hF, 1, 4'h0, 0, 4'h1, 5'd5, 0));
    vt.push_back(mk(1, 1, 4'hF, 1, 4'h0, 0, 4'h1, 5'd5, 0));
    vt.push_back(mk(1, 0, 4'hF, 1, 4'h1, 1, 4'h1, 5'd5, 0));
    vt.push_back(mk(1, 1, 4'hF, 0, 4'h0, 0, 4'h1, 5'd5, 0));
    vt.push_back(mk(1, 0, 4'hF, 1, 4'h0, 0, 4'h2, 5'd0, 0));
    vt.push_back(mk(0, 0, 4'hF, 0, 4'h0, 0, 4'h0, 5'd0, 0));
    vt.push_back(mk(1, 0, 4'hA, 1, 4'h0, 0, 4'h2, 5'd0, 0));
    vt.push_back(mk(1, 0, 4'hA, 1, 4'h2, 0, 4'h2, 5'd0, 0));
    vt.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 4'h2, 5'd0, 0));
    vt.push_back(mk(1, 0, 4'h4, 1, 4'h0, 0, 4'h3, 5'd8, 0));
    vt.push_back(mk(1, 0, 4'h4, 1, 4'h4, 1, 4'h3, 5'd8, 0));
    vt.push_back(mk(1, 0, 4'h0, 0, 4'h0, 0, 4'h3, 5'd8, 0));

    for (int v = 0; v < vt.size(); v++) begin
      reset_n = vt[v].rst_n; stall = vt[v].stall; req = vt[v].req;
      @(posedge clk); #1;
      chk($sformatf("vec%0d.busy", v), 32'(busy),         32'(vt[v].busy));
      chk($sformatf("vec%0d.ack",  v), 32'(ack),          32'(vt[v].ack));
      chk($sformatf("vec%0d.rw",   v), 32'(RegWrite),     32'(vt[v].rw));
      chk($sformatf("vec%0d.mtr",  v), 32'(MemtoReg),     32'(vt[v].mtr));
      chk($sformatf("vec%0d.wra",  v), 32'(WriteRegAddr), 32'(vt[v].wra));
      chk($sformatf("vec%0d.err",  v), 32'(sel_err),      32'(vt[v].err));
    end

    // Select changes while the request is blocked by stall; the grant must sample the new value.
    req = 4'h1; stall = 1'b1; req_sel = 16'hB327;
    @(posedge clk); #1; chk("hs.stall_busy0", 32'(busy), 32'd0);
    @(posedge clk); #1; chk("hs.stall_busy1", 32'(busy), 32'd0);
    req_sel = 16'hB326; stall = 1'b0;
    @(posedge clk); #1;
    chk("hs.grant_mtr", 32'(MemtoReg), 32'd6);
    chk("hs.grant_wra", 32'(WriteRegAddr), 32'd5);
    @(posedge clk); #1;
    chk("hs.write_ack", 32'(ack), 32'h1);
    chk("hs.write_rw",  32'(RegWrite), 32'd1);
    req = '0;
    @(posedge clk); #1; chk("hs.idle", 32'(busy), 32'd0);

    // Randomized traffic against the model, starting from a reset.
    reset_n = 1'b0; stall = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      model_step();
      #1;
      e_ack = '0;
      if (m_ph == 2) e_ack[m_g] = 1'b1;
      chk("rnd.busy", 32'(busy),         32'(m_ph != 0));
      chk("rnd.ack",  32'(ack),          32'(e_ack));
      chk("rnd.rw",   32'(RegWrite),     32'(m_ph == 2 && m_sel <= 4'd8 && m_dst != 5'd0));
      chk("rnd.err",  32'(sel_err),      32'(m_ph == 2 && m_sel > 4'd8));
      chk("rnd.mtr",  32'(MemtoReg),     32'(m_sel));
      chk("rnd.wra",  32'(WriteRegAddr), 32'(m_dst));
      reset_n = ($urandom_range(0, 99) != 0);
      stall   = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (e_ack[i])    req[i] = 1'($urandom_range(0, 1));
        else if (!req[i]) req[i] = ($urandom_range(0, 2) == 0);
        if (!(m_ph != 0 && m_g == i) && $urandom_range(0, 3) == 0) begin
          req_sel[4*i +: 4] = 4'($urandom_range(0, 11));
          req_dst[5*i +: 5] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
